// File: rtl/adapter_from_bus_pkg.sv
// Shared adapter types: the collect/drain state encoding and the 16-bit size
// carried alongside each word on the PipeInLength side.
package adapter_from_bus_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } adapterState_t;

  localparam int SIZE_WIDTH = 16;

  typedef logic [SIZE_WIDTH-1:0] pipeSize_t;

  // Bit count of a word made of `beats` beats, truncated to the size field.
  function automatic pipeSize_t beatsToSize(input int beats, input int beatWidth);
    return pipeSize_t'(beats * beatWidth);
  endfunction

endpackage

// File: rtl/adapter_from_bus.sv
// Gathers owidth-bit bus beats (first beat in the MSBs) into one width-bit word
// and hands the word, with its valid bit count, to a PipeInLength consumer.
//
// Handshakes: a beat moves when in_enq__ENA is high on a rising CLK edge while
// in_enq__RDY is high; a word moves when out_enq__ENA and out_enq__RDY are both
// high on a rising CLK edge. Both ready/valid outputs come from the state
// register only, so neither depends combinationally on any input.
module adapter_from_bus
  import adapter_from_bus_pkg::*;
#(
  parameter int width  = 128,
  parameter int owidth = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_enq__ENA,
  input  logic [owidth-1:0] in_enq_v,
  input  logic              in_enq_last,
  output logic              in_enq__RDY,
  output logic              out_enq__ENA,
  output logic [width-1:0]  out_enq_v,
  output pipeSize_t         out_enq_size,
  input  logic              out_enq__RDY,
  output logic              overflow,
  output adapterState_t     dbgState
);

  localparam int BEATS = width / owidth;
  localparam int CW    = $clog2(BEATS + 1);

  if ((width % owidth) != 0 || BEATS < 2 || width > 65535) begin : g_bad_params
    $error("adapter_from_bus: width must be a multiple of owidth, >= 2 beats, <= 65535 bits");
  end

  adapterState_t  state;
  logic [CW-1:0]  beatCnt;
  logic [width-1:0] buffer;
  pipeSize_t      sizeReg;
  logic           overflowReg;

  logic lastSlot;
  assign lastSlot = (beatCnt == CW'(BEATS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= COLLECT;
      beatCnt     <= '0;
      buffer      <= '0;
      sizeReg     <= '0;
      overflowReg <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_enq__ENA) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beatCnt == CW'(k)) begin
                buffer[width-1-k*owidth -: owidth] <= in_enq_v;
              end
            end
            beatCnt <= beatCnt + CW'(1);
            if (in_enq_last || lastSlot) begin
              state   <= DRAIN;
              sizeReg <= beatsToSize(int'(beatCnt) + 1, owidth);
              // A full buffer without last is a forced close; remember it.
              if (!in_enq_last) begin
                overflowReg <= 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          // Beats offered here are protocol violations and are ignored.
          if (out_enq__RDY) begin
            state   <= COLLECT;
            beatCnt <= '0;
            buffer  <= '0;
            sizeReg <= '0;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  assign in_enq__RDY  = (state == COLLECT);
  assign out_enq__ENA = (state == DRAIN);
  assign out_enq_v    = (state == DRAIN) ? buffer  : '0;
  assign out_enq_size = (state == DRAIN) ? sizeReg : '0;
  assign overflow     = overflowReg;
  assign dbgState     = state;

endmodule

// File: doc/adapter_from_bus.md
ADAPTER_FROM_BUS -- requirements
Module: adapter_from_bus

Interface
REQ-001 The block SHALL have parameter width, default 128, giving the assembled word width in bits.
REQ-002 The block SHALL have parameter owidth, default 32, giving the bus beat width in bits; width SHALL be a multiple of owidth, with width/owidth >= 2 and width <= 65535.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 in.enq__ENA  input  1  beat transfer strobe (PipeInLast server); asserted only while in.enq__RDY=1.
REQ-006 in.enq$v  input  owidth  beat data.
REQ-007 in.enq$last  input  1  final beat of the current word.
REQ-008 in.enq__RDY  output  1  block can accept a beat this cycle.
REQ-009 out.enq__ENA  output  1  assembled word valid (PipeInLength client).
REQ-010 out.enq$v  output  width  assembled word, first beat in the MSBs.
REQ-011 out.enq$size  output  16  valid bit count of out.enq$v.
REQ-012 out.enq__RDY  input  1  consumer accepts the word this cycle.
REQ-013 overflow  output  1  sticky: a word was closed by a full buffer rather than by last.

Function
REQ-014 The block SHALL implement two states: COLLECT (in.enq__RDY=1, out.enq__ENA=0) and DRAIN (in.enq__RDY=0, out.enq__ENA=1).
REQ-015 In COLLECT, beat k (k counted from 0 within the word) SHALL be written to buffer bits [width-1-k*owidth -: owidth], and the beat counter SHALL increment.
REQ-016 Unwritten buffer bits SHALL be zero; the buffer SHALL be cleared when a word leaves DRAIN.
REQ-017 A beat with last=1 SHALL close the word: next state DRAIN, size = (k+1)*owidth, truncated to 16 bits.
REQ-018 A beat that fills the buffer (k+1 = width/owidth) with last=0 SHALL close the word with size=width and set overflow; the next beat SHALL start a new word.
REQ-019 A beat with last=1 that also fills the buffer SHALL close the word normally, without setting overflow.
REQ-020 In DRAIN, out.enq$v and out.enq$size SHALL hold stable until out.enq__RDY=1; the transfer completes in that cycle and the next state is COLLECT with counter=0.
REQ-021 When out.enq__ENA=0, out.enq$v and out.enq$size SHALL be driven to 0.
REQ-022 There SHALL be no combinational path from in.* to out.* or from out.enq__RDY to in.enq__RDY.
REQ-023 Latency: out.enq__ENA SHALL assert on the cycle after the closing beat; an N-beat word SHALL occupy N+1 cycles minimum.
REQ-024 An in.enq__ENA while in.enq__RDY=0 is a protocol violation; it SHALL be ignored and SHALL NOT alter state.
REQ-025 overflow SHALL remain set until reset.

Reset
REQ-026 Assertion of RST SHALL immediately force: state COLLECT, counter 0, buffer 0, overflow 0, out.enq__ENA 0, out.enq$v 0, out.enq$size 0, in.enq__RDY 1 after release.
REQ-027 A reset asserted mid-word or in DRAIN SHALL discard the partial or pending word with no output transfer.
REQ-028 The first rising CLK edge after RST deassertion SHALL be able to accept a beat.

Structure
REQ-029 The state enum (COLLECT, DRAIN) SHALL reside in the shared adapter package, alongside the 16-bit size type used by the PipeInLength interface.
REQ-030 The beat counter width SHALL be $clog2(width/owidth+1).
REQ-031 The block SHALL be a single module with no sub-modules; it SHALL reuse the existing PipeInLast and PipeInLength interfaces unchanged.

Verification
REQ-032 Four beats 0xAAAA0001..0xAAAA0004, last on the 4th, out.RDY=1 -> v=0xAAAA0001AAAA0002AAAA0003AAAA0004, size=128, ENA for exactly 1 cycle, overflow=0.
REQ-033 Two beats 0x11111111, 0x22222222, last on the 2nd -> v=0x11111111222222220000000000000000, size=64.
REQ-034 Single beat 0xDEADBEEF with last=1, out.RDY=0 for 5 cycles -> ENA and v held stable, in.RDY=0 throughout; completion on the cycle RDY rises; in.RDY=1 on the next cycle.
REQ-035 Six beats, never last -> first word of 4 beats with size=128 and overflow=1; second word closes only on a later last.
REQ-036 RST pulsed after 2 of 4 beats, then a fresh 1-beat word 0x5 with last -> no output for the partial word; output v=0x5<<96, size=32.
REQ-037 Back-to-back words with out.RDY=1 -> no lost or duplicated beats, one idle in.RDY cycle per word, matching the TX-side AdapterToBus round-trip scoreboard.
